// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants: framing bytes, CRC-32 parameters, FSM encoding.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Receive FSM encoding
  localparam logic [2:0]  StIdle  = 3'd0;
  localparam logic [2:0]  StPre   = 3'd1;
  localparam logic [2:0]  StData  = 3'd2;
  localparam logic [2:0]  StAbort = 3'd3;
  localparam logic [2:0]  StDrop  = 3'd4;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte in, then shift out eight bits one at a time
  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, forwards payload, withholds and checks the FCS.
module gmii_rx_frame
  import eth_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        crc_ok,
  output logic        len_err
);

  localparam logic [10:0] MaxLenP1 = 11'(MAX_LEN + 1);
  localparam logic [10:0] MinLen   = 11'(MIN_LEN);
  // Five bytes of delay: the newest four are the FCS candidate at frame end
  localparam logic [10:0] LineFull = 11'd5;

  logic [2:0]      state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [10:0]     bcnt_q, bcnt_d, bcnt_inc;
  logic [31:0]     crc_q, crc_d, crc_next;
  logic [4:0][7:0] line_q, line_d;

  logic        valid_d, sof_d, eof_d, done_d, crc_ok_d, len_err_d;
  logic [7:0]  data_d;
  logic [10:0] len_d;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_next)
  );

  assign bcnt_inc = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;

  // Next-state, counters, delay line and the next value of every registered output
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    crc_d     = crc_q;
    line_d    = line_q;
    valid_d   = 1'b0;
    data_d    = 8'h00;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    done_d    = 1'b0;
    len_d     = 11'd0;
    crc_ok_d  = 1'b0;
    len_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d = StPre;
            pcnt_d  = 3'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end

      StPre: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          pcnt_d = (pcnt_q == 3'd7) ? pcnt_q : pcnt_q + 3'd1;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d = StData;
          crc_d   = CRC_INIT;
          bcnt_d  = 11'd0;
        end else begin
          state_d = StDrop;
        end
      end

      StData: begin
        if (gmii_rx_dv) begin
          crc_d  = crc_next;
          bcnt_d = bcnt_inc;
          line_d = {line_q[3:0], gmii_rxd};
          if (bcnt_q >= LineFull) begin
            valid_d = 1'b1;
            data_d  = line_q[4];
            sof_d   = (bcnt_q == LineFull);
          end
          if (bcnt_inc == MaxLenP1) begin
            state_d = StAbort;
          end
        end else begin
          // Frame end: oldest byte is the last payload byte, the rest is FCS
          if (bcnt_q >= LineFull) begin
            valid_d = 1'b1;
            data_d  = line_q[4];
            sof_d   = (bcnt_q == LineFull);
            eof_d   = 1'b1;
          end
          done_d    = 1'b1;
          len_d     = bcnt_q;
          crc_ok_d  = (crc_q == CRC_RESIDUE);
          len_err_d = (bcnt_q < MinLen);
          line_d    = '0;
          state_d   = StIdle;
        end
      end

      StAbort: begin
        if (!gmii_rx_dv) begin
          done_d    = 1'b1;
          len_d     = bcnt_q;
          len_err_d = 1'b1;
          line_d    = '0;
          state_d   = StIdle;
        end
      end

      StDrop: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State, CRC and delay-line registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pcnt_q  <= 3'd0;
      bcnt_q  <= 11'd0;
      crc_q   <= CRC_INIT;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      crc_q   <= crc_d;
      line_q  <= line_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= 11'd0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_sof    <= sof_d;
      out_eof    <= eof_d;
      frame_done <= done_d;
      frame_len  <= len_d;
      crc_ok     <= crc_ok_d;
      len_err    <= len_err_d;
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Directed bench for gmii_rx_frame with a payload/status scoreboard.
module tb_gmii_rx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;
  logic [10:0] frame_len;
  logic        crc_ok;
  logic        len_err;

  gmii_rx_frame #(
    .MAX_LEN (1518),
    .MIN_LEN (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rxd   (gmii_rxd),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .crc_ok     (crc_ok),
    .len_err    (len_err)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  typedef struct packed {
    logic [10:0] len;
    logic        ok;
    logic        lerr;
  } stat_t;

  beat_t      exp_q[$];
  stat_t      stat_q[$];
  logic [7:0] frame[$];
  int         n_vec = 0;
  int         n_err = 0;

  // Bit-serial reference CRC over the current frame buffer
  function automatic logic [31:0] ref_crc();
    logic [31:0] c = 32'hFFFFFFFF;
    logic        fb;
    foreach (frame[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ frame[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic build(input int n_data);
    logic [31:0] fcs;
    frame.delete();
    for (int i = 0; i < n_data; i++) frame.push_back(8'($urandom_range(0, 255)));
    fcs = ~ref_crc();
    frame.push_back(fcs[7:0]);
    frame.push_back(fcs[15:8]);
    frame.push_back(fcs[23:16]);
    frame.push_back(fcs[31:24]);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    @(negedge clk);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  // Push expectations for the buffered frame, then drive preamble, SFD, bytes, one gap cycle
  task automatic send(input logic exp_ok);
    int    n;
    int    last;
    stat_t s;
    n = frame.size();
    if (n > 1518) begin
      for (int i = 0; i < 1514; i++) exp_q.push_back('{frame[i], (i == 0), 1'b0});
      s = '{11'd1519, 1'b0, 1'b1};
    end else begin
      last = n - 5;
      for (int i = 0; i <= last; i++) exp_q.push_back('{frame[i], (i == 0), (i == last)});
      s = '{11'(n), exp_ok, (n < 64)};
    end
    stat_q.push_back(s);
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    foreach (frame[k]) drive(1'b1, frame[k]);
    drive(1'b0, 8'h00);
  endtask

  // Output monitor, sampling mid-cycle away from the active edge
  always @(negedge clk) begin
    beat_t got_b, exp_b;
    stat_t got_s, exp_s;
    if (out_valid) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL stray_byte got=%02h sof=%0b eof=%0b expected no byte", out_data, out_sof,
               out_eof);
      end
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        got_b = '{out_data, out_sof, out_eof};
        n_vec++;
        assert (got_b === exp_b) else begin
          n_err++;
          $error("FAIL payload got data=%02h sof=%0b eof=%0b expected data=%02h sof=%0b eof=%0b",
                 got_b.data, got_b.sof, got_b.eof, exp_b.data, exp_b.sof, exp_b.eof);
        end
      end
      if (out_eof) begin
        n_vec++;
        assert (frame_done === 1'b1) else begin
          n_err++;
          $error("FAIL eof_done_align got frame_done=%0b expected 1", frame_done);
        end
      end
    end
    if (frame_done) begin
      n_vec++;
      assert (stat_q.size() > 0) else begin
        n_err++;
        $error("FAIL stray_done got len=%0d expected no frame_done", frame_len);
      end
      if (stat_q.size() > 0) begin
        exp_s = stat_q.pop_front();
        got_s = '{frame_len, crc_ok, len_err};
        n_vec++;
        assert (got_s === exp_s) else begin
          n_err++;
          $error("FAIL status got len=%0d crc_ok=%0b len_err=%0b expected len=%0d crc_ok=%0b len_err=%0b",
                 got_s.len, got_s.ok, got_s.lerr, exp_s.len, exp_s.ok, exp_s.lerr);
        end
      end
    end
  end

  task automatic check_drained(input string tag);
    n_vec++;
    assert (exp_q.size() === 0) else begin
      n_err++;
      $error("FAIL %s_bytes_pending got=%0d expected 0", tag, exp_q.size());
    end
    n_vec++;
    assert (stat_q.size() === 0) else begin
      n_err++;
      $error("FAIL %s_status_pending got=%0d expected 0", tag, stat_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [24:0] got;
    got = {out_valid, out_data, out_sof, out_eof, frame_done, frame_len, crc_ok, len_err};
    n_vec++;
    assert (got === 25'd0) else begin
      n_err++;
      $error("FAIL %s got=%07h expected 0000000", tag, got);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    idle(3);

    // Valid minimum-length frame
    build(60);
    send(1'b1);
    idle(4);
    check_drained("valid64");

    // One data bit flipped after the FCS was computed
    build(60);
    frame[20] = frame[20] ^ 8'h10;
    send(1'b0);
    idle(4);
    check_drained("bitflip");

    // Two frames separated by a single dv=0 cycle
    build(60);
    send(1'b1);
    build(100);
    send(1'b1);
    idle(4);
    check_drained("back2back");

    // Runt: three bytes, no FCS
    frame.delete();
    frame.push_back(8'h01);
    frame.push_back(8'h02);
    frame.push_back(8'h03);
    send(1'b0);
    idle(4);
    check_drained("runt");

    // Oversize: aborts after MAX_LEN+1 bytes
    frame.delete();
    for (int i = 0; i < 1600; i++) frame.push_back(8'($urandom_range(0, 255)));
    send(1'b0);
    idle(4);
    check_drained("oversize");

    // Bad preamble, including an SFD that must not restart the frame
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    drive(1'b1, 8'h11);
    idle(4);
    check_drained("bad_preamble");

    // Reset asserted mid-DATA after 8 bytes: bytes 0..2 were already emitted
    build(60);
    for (int i = 0; i < 3; i++) exp_q.push_back('{frame[i], (i == 0), 1'b0});
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 8; i++) drive(1'b1, frame[i]);
    @(negedge clk);
    n_vec++;
    assert (out_valid === 1'b1) else begin
      n_err++;
      $error("FAIL pre_reset_valid got=%0b expected 1", out_valid);
    end
    #2;
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    #1;
    check_outputs_zero("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_drained("reset");

    // Clean frame after the reset
    build(60);
    send(1'b1);
    idle(6);
    check_drained("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
